// File: rtl/sample_fifo_pkg.sv
// Shared constants, sample type and FSM encoding for the DCTC sample responder.
package sample_fifo_pkg;

  localparam int unsigned DATA_W    = 32'd18;
  localparam int unsigned ADDR_W    = 32'd8;
  localparam int unsigned FRAME_LEN = 32'd26;
  localparam int unsigned RAM_AW    = $clog2(FRAME_LEN);

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(FRAME_LEN - 32'd1);
  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_LEN);

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARM   = 2'd2,
    SERVE = 2'd3
  } fifo_state_t;

  function automatic logic addr_in_frame(input logic [ADDR_W-1:0] addr);
    return (addr < FRAME_END);
  endfunction

endpackage

// File: rtl/sample_fifo_resp_if.sv
// Write, read and consumer-handshake bundle between the responder and its neighbours.
interface sample_fifo_resp_if;
  import sample_fifo_pkg::*;

  logic                  wr_valid;
  sample_t               wr_data;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     fifo_addr;
  logic                  fifo_read;
  sample_t               fifo_sample;
  logic                  fifo_sample_valid;
  logic                  rd_err;
  logic                  consumer_start;
  logic                  consumer_done;

  modport master (
    output wr_valid, wr_data, fifo_addr, fifo_read, consumer_done,
    input  wr_ready, fifo_sample, fifo_sample_valid, rd_err, consumer_start
  );

  modport slave (
    input  wr_valid, wr_data, fifo_addr, fifo_read, consumer_done,
    output wr_ready, fifo_sample, fifo_sample_valid, rd_err, consumer_start
  );

endinterface

// File: rtl/sample_ram.sv
// One-frame sample store: one write port, one synchronous read port with a registered
// output that can also be forced to zero for rejected reads.
module sample_ram
  import sample_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [RAM_AW-1:0] wr_addr,
  input  sample_t           wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [RAM_AW-1:0] rd_addr,
  output sample_t           rd_data
);

  sample_t mem_r [FRAME_LEN];
  sample_t rd_data_r;

  // storage array is left unreset; every read is qualified by the FSM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // output register holds between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else if (rd_clr) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/sample_fifo_resp.sv
// DCTC sample-read responder: captures a frame, starts the consumer, serves addressed reads.
// Optional drop counter enabled by defining SAMPLE_FIFO_DROP_CNT_EN.
module sample_fifo_resp
  import sample_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_enable,
  sample_fifo_resp_if.slave bus,
  output logic              frame_ready,
  output logic [7:0]        frame_cnt,
  output logic [7:0]        drop_cnt
);

  fifo_state_t       state_r;
  fifo_state_t       next_state_s;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic              done_q_r;
  logic              done_rise_s;
  logic              last_wr_s;
  logic              wr_ready_s;
  logic              wr_en_s;
  logic              rd_ok_s;
  logic              rd_bad_s;
  logic              fifo_sample_valid_r;
  logic              rd_err_r;
  logic              consumer_start_r;
  logic              frame_ready_r;
  logic [7:0]        frame_cnt_r;
  sample_t           fifo_sample_s;

  assign done_rise_s = bus.consumer_done & ~done_q_r;
  assign wr_en_s     = bus.wr_valid & wr_ready_s;
  assign last_wr_s   = wr_en_s & (wr_ptr_r == LAST_PTR);

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state; dropping cfg_enable mid-fill abandons the partial frame
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cfg_enable) next_state_s = FILL;
        else            next_state_s = IDLE;
      end
      FILL: begin
        if (!cfg_enable)    next_state_s = IDLE;
        else if (last_wr_s) next_state_s = ARM;
        else                next_state_s = FILL;
      end
      ARM: begin
        next_state_s = SERVE;
      end
      SERVE: begin
        if (done_rise_s) begin
          if (cfg_enable) next_state_s = FILL;
          else            next_state_s = IDLE;
        end else begin
          next_state_s = SERVE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // output decode: write acceptance and read classification
  always_comb begin
    wr_ready_s = 1'b0;
    rd_ok_s    = 1'b0;
    rd_bad_s   = 1'b0;
    case (state_r)
      FILL:    wr_ready_s = 1'b1;
      default: wr_ready_s = 1'b0;
    endcase
    if (bus.fifo_read) begin
      if ((state_r == SERVE) && addr_in_frame(bus.fifo_addr)) begin
        rd_ok_s = 1'b1;
      end else begin
        rd_bad_s = 1'b1;
      end
    end else begin
      rd_ok_s  = 1'b0;
      rd_bad_s = 1'b0;
    end
  end

  // write pointer and consumer_done history
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      done_q_r <= 1'b0;
    end else begin
      done_q_r <= bus.consumer_done;
      case (state_r)
        FILL: begin
          if (!cfg_enable)  wr_ptr_r <= {ADDR_W{1'b0}};
          else if (wr_en_s) wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          else              wr_ptr_r <= wr_ptr_r;
        end
        SERVE: begin
          if (done_rise_s) wr_ptr_r <= {ADDR_W{1'b0}};
          else             wr_ptr_r <= wr_ptr_r;
        end
        default: begin
          wr_ptr_r <= wr_ptr_r;
        end
      endcase
    end
  end

  // registered handshake and status outputs; start is high for the single ARM cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_sample_valid_r <= 1'b0;
      rd_err_r            <= 1'b0;
      consumer_start_r    <= 1'b0;
      frame_ready_r       <= 1'b0;
      frame_cnt_r         <= 8'd0;
    end else begin
      fifo_sample_valid_r <= rd_ok_s;
      rd_err_r            <= rd_bad_s;
      consumer_start_r    <= (next_state_s == ARM);
      if (state_r == ARM) begin
        frame_ready_r <= 1'b1;
        frame_cnt_r   <= frame_cnt_r + 8'd1;
      end else if ((state_r == SERVE) && done_rise_s) begin
        frame_ready_r <= 1'b0;
        frame_cnt_r   <= frame_cnt_r;
      end else begin
        frame_ready_r <= frame_ready_r;
        frame_cnt_r   <= frame_cnt_r;
      end
    end
  end

  sample_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r[RAM_AW-1:0]),
    .wr_data (bus.wr_data),
    .rd_en   (rd_ok_s),
    .rd_clr  (rd_bad_s),
    .rd_addr (bus.fifo_addr[RAM_AW-1:0]),
    .rd_data (fifo_sample_s)
  );

`ifdef SAMPLE_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_r;

  // saturating count of writes offered while the buffer is closed
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_r <= 8'd0;
    end else if (cfg_enable && bus.wr_valid && !wr_ready_s && (drop_cnt_r != 8'd255)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  assign drop_cnt = 8'd0;
`endif

  assign bus.wr_ready          = wr_ready_s;
  assign bus.fifo_sample       = fifo_sample_s;
  assign bus.fifo_sample_valid = fifo_sample_valid_r;
  assign bus.rd_err            = rd_err_r;
  assign bus.consumer_start    = consumer_start_r;
  assign frame_ready           = frame_ready_r;
  assign frame_cnt             = frame_cnt_r;

endmodule

// File: tb/tb_sample_fifo_resp.sv
// Scoreboard bench for sample_fifo_resp: reads push expected responses, a negedge monitor
// pops and compares; frames, recycle, abort, drops and reset are exercised in sequence.
module tb_sample_fifo_resp;
  import sample_fifo_pkg::*;

  typedef struct packed {
    logic          valid;
    logic          err;
    logic [DATA_W-1:0] sample;
  } rd_exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_enable;
  logic       frame_ready;
  logic [7:0] frame_cnt;
  logic [7:0] drop_cnt;

  sample_fifo_resp_if bus_if();

  sample_fifo_resp dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_enable  (cfg_enable),
    .bus         (bus_if),
    .frame_ready (frame_ready),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int start_seen     = 0;
  int start_expected = 0;
  int frames_done    = 0;
  logic serving = 1'b0;
  logic [DATA_W-1:0] ref_frame [FRAME_LEN];
  logic [DATA_W-1:0] last_sample = '0;
  rd_exp_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // response monitor
  always @(negedge clk) begin
    rd_exp_t e;
    if (bus_if.consumer_start === 1'b1) start_seen++;
    if (bus_if.fifo_sample_valid === 1'b1 || bus_if.rd_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rd_valid", 32'(bus_if.fifo_sample_valid), 32'(e.valid));
        check("rd_err", 32'(bus_if.rd_err), 32'(e.err));
        check("rd_sample", 32'(bus_if.fifo_sample), 32'(e.sample));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr);
    rd_exp_t e;
    if (serving && (int'(addr) < int'(FRAME_LEN))) begin
      e.valid  = 1'b1;
      e.err    = 1'b0;
      e.sample = ref_frame[int'(addr)];
    end else begin
      e.valid  = 1'b0;
      e.err    = 1'b1;
      e.sample = '0;
    end
    last_sample = e.sample;
    exp_q.push_back(e);
    bus_if.fifo_read = 1'b1;
    bus_if.fifo_addr = addr;
    idle(1);
    bus_if.fifo_read = 1'b0;
    bus_if.fifo_addr = 8'($urandom);
  endtask

  task automatic write_sample(input logic [DATA_W-1:0] d);
    int n = 0;
    while (bus_if.wr_ready !== 1'b1 && n < 20) begin
      idle(1);
      n++;
    end
    check("wr_ready_before_write", 32'(bus_if.wr_ready), 32'd1);
    bus_if.wr_valid = 1'b1;
    bus_if.wr_data  = d;
    idle(1);
    bus_if.wr_valid = 1'b0;
    bus_if.wr_data  = DATA_W'($urandom);
  endtask

  task automatic write_frame(input bit fixed);
    logic [DATA_W-1:0] pend [FRAME_LEN];
    int n = 0;
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      pend[i] = fixed ? DATA_W'(32'h100 + i) : DATA_W'($urandom);
      write_sample(pend[i]);
      if (i < int'(FRAME_LEN) - 1) idle($urandom_range(0, 2));
    end
    ref_frame = pend;
    start_expected++;
    frames_done++;
    while (frame_ready !== 1'b1 && n < 10) begin
      idle(1);
      n++;
    end
    check("frame_ready_set", 32'(frame_ready), 32'd1);
    check("start_pulses", 32'(start_seen), 32'(start_expected));
    check("frame_cnt", 32'(frame_cnt), 32'(frames_done % 256));
    check("wr_ready_serve", 32'(bus_if.wr_ready), 32'd0);
    serving = 1'b1;
  endtask

  task automatic check_reset_vals();
    check("rst_wr_ready", 32'(bus_if.wr_ready), 32'd0);
    check("rst_fifo_sample", 32'(bus_if.fifo_sample), 32'd0);
    check("rst_sample_valid", 32'(bus_if.fifo_sample_valid), 32'd0);
    check("rst_rd_err", 32'(bus_if.rd_err), 32'd0);
    check("rst_consumer_start", 32'(bus_if.consumer_start), 32'd0);
    check("rst_frame_ready", 32'(frame_ready), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    cfg_enable = 1'b0;
    bus_if.wr_valid = 1'b0;
    bus_if.wr_data = '0;
    bus_if.fifo_addr = '0;
    bus_if.fifo_read = 1'b0;
    bus_if.consumer_done = 1'b0;
    idle(3);
    check_reset_vals();
    reset = 1'b0;

    // idle: reads rejected, writes ignored and not counted while disabled
    do_read(8'd3);
    bus_if.wr_valid = 1'b1;
    idle(4);
    bus_if.wr_valid = 1'b0;
    check("idle_wr_ready", 32'(bus_if.wr_ready), 32'd0);
    check("idle_drop_cnt", 32'(drop_cnt), 32'd0);

    cfg_enable = 1'b1;
    idle(1);
    write_frame(1'b1);
    for (int a = 18; a < 26; a++) begin
      do_read(8'(a));
      idle($urandom_range(0, 1));
    end
    do_read(8'd26);
    do_read(8'd255);
    repeat (20) do_read(8'($urandom_range(0, 31)));
    idle(3);
    check("sample_hold", 32'(bus_if.fifo_sample), 32'(last_sample));
    check("queue_drained_1", 32'(exp_q.size()), 32'd0);

    // writes offered while serving
    bus_if.wr_valid = 1'b1;
    idle(100);
    bus_if.wr_valid = 1'b0;
`ifdef SAMPLE_FIFO_DROP_CNT_EN
    check("drop_cnt_100", 32'(drop_cnt), 32'd100);
`else
    check("drop_cnt_100", 32'(drop_cnt), 32'd0);
`endif
    bus_if.wr_valid = 1'b1;
    idle(200);
    bus_if.wr_valid = 1'b0;
`ifdef SAMPLE_FIFO_DROP_CNT_EN
    check("drop_cnt_sat", 32'(drop_cnt), 32'd255);
`else
    check("drop_cnt_sat", 32'(drop_cnt), 32'd0);
`endif
    do_read(8'd0);
    do_read(8'd25);
    check("frame_cnt_after_drops", 32'(frame_cnt), 32'd1);

    // recycle on consumer_done rise, then hold it high through the next frame
    bus_if.consumer_done = 1'b1;
    serving = 1'b0;
    idle(1);
    check("recycle_wr_ready", 32'(bus_if.wr_ready), 32'd1);
    check("recycle_frame_ready", 32'(frame_ready), 32'd0);
    do_read(8'd5);
    write_frame(1'b0);
    idle(10);
    check("held_done_frame_ready", 32'(frame_ready), 32'd1);
    check("held_done_wr_ready", 32'(bus_if.wr_ready), 32'd0);
    check("held_done_frame_cnt", 32'(frame_cnt), 32'd2);
    repeat (30) do_read(8'($urandom_range(0, 31)));

    // recycle with capture disabled lands in IDLE
    bus_if.consumer_done = 1'b0;
    idle(2);
    cfg_enable = 1'b0;
    bus_if.consumer_done = 1'b1;
    serving = 1'b0;
    idle(3);
    check("to_idle_frame_ready", 32'(frame_ready), 32'd0);
    check("to_idle_wr_ready", 32'(bus_if.wr_ready), 32'd0);
    bus_if.consumer_done = 1'b0;

    // abort a partial frame
    cfg_enable = 1'b1;
    idle(1);
    repeat (10) write_sample(DATA_W'($urandom));
    cfg_enable = 1'b0;
    idle(20);
    check("abort_wr_ready", 32'(bus_if.wr_ready), 32'd0);
    check("abort_frame_ready", 32'(frame_ready), 32'd0);
    check("abort_no_start", 32'(start_seen), 32'(start_expected));
    check("abort_frame_cnt", 32'(frame_cnt), 32'd2);

    cfg_enable = 1'b1;
    idle(1);
    write_frame(1'b0);
    for (int a = 0; a < int'(FRAME_LEN); a++) do_read(8'(a));
    idle(3);
    check("queue_drained_2", 32'(exp_q.size()), 32'd0);

    // synchronous reset while serving
    cfg_enable = 1'b0;
    reset = 1'b1;
    serving = 1'b0;
    idle(1);
    check_reset_vals();
    reset = 1'b0;
    idle(3);
    check("post_reset_wr_ready", 32'(bus_if.wr_ready), 32'd0);
    check("pending_reads", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
